smc_stream: RTL and testbench

Streaming, parametrised successor of the combinational six-transistor sort-and-sum calculator. Accepts one MOSFET (W, V_GS, V_DS) per handshake beat and computes its drain current I_D or transconductance g_m. Keeps a running sorted top-3 or bottom-3 of a batch of `N_DEV` devices. Emits one plain or weighted sum per batch over a valid/ready output. It sits between the stimulus/host interface and the result collector, and replaces the fixed-six-input, single-cycle version.

---
 rtl/smc_pkg.sv | 33 +++
 rtl/smc_stream_if.sv | 28 ++
 rtl/smc_dev_calc.sv | 43 ++++
 rtl/smc_stream.sv | 145 ++++++++++++++
 tb/tb_smc_stream.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/smc_pkg.sv
// smc_pkg: shared mode encodings, FSM state type, sum weights and width
// helpers for the streaming sort-and-sum MOSFET calculator.
package smc_pkg;

  // mode[0] picks the metric (0 = g_m, 1 = I_D), mode[1] picks min/max
  localparam logic [1:0] MODE_GM_MIN = 2'b00;
  localparam logic [1:0] MODE_ID_MIN = 2'b01;
  localparam logic [1:0] MODE_GM_MAX = 2'b10;
  localparam logic [1:0] MODE_ID_MAX = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SUM,
    OUT
  } state_t;

  // weights applied to s0, s1, s2 in the weighted (I_D) sum
  localparam int W_S0 = 3;
  localparam int W_S1 = 4;
  localparam int W_S2 = 5;

  // width of a per-device value
  function automatic int vw_of(input int dw);
    return 3 * dw;
  endfunction

  // width of the batch result, room for 12x the largest value
  function automatic int ow_of(input int dw);
    return 3 * dw + 4;
  endfunction

endpackage

// File: rtl/smc_stream_if.sv
// smc_stream_if: device-beat input stream plus result output stream.
interface smc_stream_if #(
  parameter int DW = 3
);

  logic                           in_valid;
  logic                           in_ready;
  logic [1:0]                     mode;
  logic [DW-1:0]                  w;
  logic [DW-1:0]                  vgs;
  logic [DW-1:0]                  vds;
  logic                           out_valid;
  logic                           out_ready;
  logic [smc_pkg::ow_of(DW)-1:0]  out_data;

  // host / collector side
  modport master (
    output in_valid, mode, w, vgs, vds, out_ready,
    input  in_ready, out_valid, out_data
  );

  // calculator side
  modport slave (
    input  in_valid, mode, w, vgs, vds, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/smc_dev_calc.sv
// smc_dev_calc: combinational square-law model of one MOSFET, giving drain
// current and transconductance, both floor-divided by 3.
module smc_dev_calc
  import smc_pkg::*;
#(
  parameter int DW = 3,
  parameter int VT = 1
) (
  input  logic [DW-1:0]        w,
  input  logic [DW-1:0]        vgs,
  input  logic [DW-1:0]        vds,
  output logic [vw_of(DW)-1:0] id,
  output logic [vw_of(DW)-1:0] gm
);

  localparam int VW = vw_of(DW);
  localparam int IW = VW + 1;

  logic [IW-1:0] w_e, vgs_e, vds_e, d, id_num, gm_num;

  // Region select and products at full width; cutoff forces zero instead of wrapping
  always_comb begin
    w_e    = IW'(w);
    vgs_e  = IW'(vgs);
    vds_e  = IW'(vds);
    d      = '0;
    id_num = '0;
    gm_num = '0;
    if (vgs_e > IW'(VT)) begin
      d = vgs_e - IW'(VT);
      if (d > vds_e) begin
        id_num = w_e * vds_e * ((d << 1) - vds_e);
        gm_num = (w_e * vds_e) << 1;
      end else begin
        id_num = w_e * d * d;
        gm_num = (w_e * d) << 1;
      end
    end
    id = VW'(id_num / IW'(3));
    gm = VW'(gm_num / IW'(3));
  end

endmodule

// File: rtl/smc_stream.sv
// smc_stream: per-batch FSM, beat counter, three-deep insertion sort buffer
// and plain/weighted summer, with a registered valid/ready result.
module smc_stream
  import smc_pkg::*;
#(
  parameter int N_DEV = 6,
  parameter int DW    = 3,
  parameter int VT    = 1
) (
  input  logic         clk,
  input  logic         rst,
  smc_stream_if.slave  bus
);

  localparam int VW = vw_of(DW);
  localparam int OW = ow_of(DW);
  localparam int CW = $clog2(N_DEV + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      mode_q;
  logic [VW-1:0]   s0, s1, s2;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [OW-1:0]   out_data_q;

  logic [VW-1:0]   id_v, gm_v, metric, sentinel;
  logic [VW-1:0]   b0, b1, b2, n0, n1, n2;
  logic [1:0]      eff_mode;
  logic [OW-1:0]   sum_plain, sum_weighted, sum_sel;

  smc_dev_calc #(.DW(DW), .VT(VT)) u_dev_calc (
    .w   (bus.w),
    .vgs (bus.vgs),
    .vds (bus.vds),
    .id  (id_v),
    .gm  (gm_v)
  );

  // Insert the current beat into the buffer, seeding with sentinels on the first beat
  always_comb begin
    eff_mode = (state == IDLE) ? bus.mode : mode_q;
    metric   = eff_mode[0] ? id_v : gm_v;
    sentinel = eff_mode[1] ? '0 : '1;
    b0 = (state == IDLE) ? sentinel : s0;
    b1 = (state == IDLE) ? sentinel : s1;
    b2 = (state == IDLE) ? sentinel : s2;
    n0 = b0;
    n1 = b1;
    n2 = b2;
    if (eff_mode[1]) begin
      if (metric > b0) begin
        n0 = metric;
        n1 = b0;
        n2 = b1;
      end else if (metric > b1) begin
        n1 = metric;
        n2 = b1;
      end else if (metric > b2) begin
        n2 = metric;
      end
    end else begin
      if (metric < b2) begin
        n0 = b1;
        n1 = b2;
        n2 = metric;
      end else if (metric < b1) begin
        n0 = b1;
        n1 = metric;
      end else if (metric < b0) begin
        n0 = metric;
      end
    end
  end

  // Batch result from the settled buffer: plain for g_m, weighted for I_D
  always_comb begin
    sum_plain    = OW'(s0) + OW'(s1) + OW'(s2);
    sum_weighted = OW'(s0) * OW'(W_S0) + OW'(s1) * OW'(W_S1) + OW'(s2) * OW'(W_S2);
    sum_sel      = mode_q[0] ? sum_weighted : sum_plain;
  end

  // Batch FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mode_q      <= '0;
      s0          <= '0;
      s1          <= '0;
      s2          <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mode_q <= bus.mode;
            s0     <= n0;
            s1     <= n1;
            s2     <= n2;
            cnt    <= CW'(1);
            state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.in_valid) begin
            s0  <= n0;
            s1  <= n1;
            s2  <= n2;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(N_DEV - 1)) begin
              in_ready_q <= 1'b0;
              state      <= SUM;
            end
          end
        end
        SUM: begin
          out_data_q  <= sum_sel;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt         <= '0;
            state       <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_smc_stream.sv
// tb_smc_stream: directed batches with hand-computed results for smc_stream.
module tb_smc_stream;
  import smc_pkg::*;

  localparam int N_DEV = 6;
  localparam int DW    = 3;
  localparam int VT    = 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   wv[N_DEV];
  int   gv[N_DEV];
  int   dv[N_DEV];

  smc_stream_if #(.DW(DW)) bus ();

  smc_stream #(.N_DEV(N_DEV), .DW(DW), .VT(VT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // safety net against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one beat, presented at a negedge once in_ready is high, accepted at the next posedge
  task automatic applyStimulus(input int wi, input int gi, input int di, input logic [1:0] m);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput("beat_accept", 32'(bus.in_ready), 32'd1);
    end else begin
      bus.in_valid = 1'b1;
      bus.w        = DW'(wi);
      bus.vgs      = DW'(gi);
      bus.vds      = DW'(di);
      bus.mode     = m;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic sendBatch(input logic [1:0] m_first, input logic [1:0] m_rest, input int max_gap);
    for (int k = 0; k < N_DEV; k++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      applyStimulus(wv[k], gv[k], dv[k], (k == 0) ? m_first : m_rest);
    end
  endtask

  // wait for the result, optionally stall the consumer, then complete the handshake
  task automatic collectResult(input string tag, input int exp, input int stall);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < stall; i++) begin
      checkOutput({tag, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({tag, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
      checkOutput({tag, "_stall_data"}, 32'(bus.out_data), 32'(exp));
      @(negedge clk);
    end
    checkOutput(tag, 32'(bus.out_data), 32'(exp));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    @(negedge clk);
    checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    checkOutput({tag, "_cnt"}, 32'(dut.cnt), 32'd0);
    checkOutput({tag, "_s0"}, 32'(dut.s0), 32'd0);
    checkOutput({tag, "_s1"}, 32'(dut.s1), 32'd0);
    checkOutput({tag, "_s2"}, 32'(dut.s2), 32'd0);
    checkOutput({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  // six saturated devices: I_D = 84, g_m = 28
  task automatic setSame();
    for (int k = 0; k < N_DEV; k++) begin
      wv[k] = 7; gv[k] = 7; dv[k] = 7;
    end
  endtask

  // w = k: g_m = 2k, I_D = 3k
  task automatic setRamp();
    for (int k = 0; k < N_DEV; k++) begin
      wv[k] = k + 1; gv[k] = 4; dv[k] = 7;
    end
  endtask

  // triode (I_D 1, g_m 0), two cutoffs (0, 0), three saturated (84, 28)
  task automatic setMixed();
    wv[0] = 1; gv[0] = 3; dv[0] = 1;
    wv[1] = 5; gv[1] = 1; dv[1] = 3;
    wv[2] = 7; gv[2] = 0; dv[2] = 7;
    for (int k = 3; k < N_DEV; k++) begin
      wv[k] = 7; gv[k] = 7; dv[k] = 7;
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mode      = 2'b00;
    bus.w         = '0;
    bus.vgs       = '0;
    bus.vds       = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkReset("por");

    // identical devices: 12*84 and 3*28
    setSame();
    sendBatch(MODE_ID_MAX, MODE_ID_MAX, 0);
    collectResult("same_id_max", 1008, 0);
    sendBatch(MODE_GM_MIN, MODE_GM_MIN, 0);
    collectResult("same_gm_min", 84, 0);

    // ramp: 12+10+8, 3*9+4*6+5*3, 3*18+4*15+5*12
    setRamp();
    sendBatch(MODE_GM_MAX, MODE_GM_MAX, 0);
    collectResult("ramp_gm_max", 30, 0);
    sendBatch(MODE_ID_MIN, MODE_ID_MIN, 0);
    collectResult("ramp_id_min", 66, 0);
    sendBatch(MODE_ID_MAX, MODE_ID_MAX, 0);
    collectResult("ramp_id_max", 174, 0);

    // triode and cutoff: smallest I_D are 1,0,0 -> 3; smallest g_m 0,0,0 -> 0
    setMixed();
    sendBatch(MODE_ID_MIN, MODE_ID_MIN, 0);
    collectResult("mixed_id_min", 3, 0);
    sendBatch(MODE_GM_MIN, MODE_GM_MIN, 0);
    collectResult("mixed_gm_min", 0, 0);

    // input gaps and a 5-cycle consumer stall give the same ramp result
    setRamp();
    sendBatch(MODE_ID_MAX, MODE_ID_MAX, 3);
    collectResult("stall_id_max", 174, 5);

    // mode flips after the first beat; the first-beat mode rules
    sendBatch(MODE_ID_MAX, MODE_GM_MIN, 0);
    collectResult("mode_change", 174, 0);

    // partial batch aborted by a one-cycle reset, then a fresh full batch
    for (int k = 0; k < 3; k++) applyStimulus(1, 3, 1, MODE_ID_MIN);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkReset("mid_reset");
    setRamp();
    sendBatch(MODE_ID_MAX, MODE_ID_MAX, 0);
    collectResult("after_reset", 174, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
